uart_bfm_trx: RTL and testbench
===============================

UART_BFM_TRX -- requirements
Module: uart_bfm_trx

Interface
- REQ-001 SHALL have parameter DIV_W, default 16, width of the clocks-per-bit divisor.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 8, RX FIFO entries; power of two, 2..64.
- REQ-003 SHALL have parameter DATA_BITS, default 8, character width; 5..8.
- REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
- REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
- REQ-006 SHALL have port cfg_div  in  DIV_W  clocks per bit; values below 4 are treated as 4.
- REQ-007 SHALL have port cfg_parity_en  in  1  parity bit present.
- REQ-008 SHALL have port cfg_parity_odd  in  1  odd parity when set, else even.
- REQ-009 SHALL have port cfg_stop2  in  1  two stop bits when set, else one.
- REQ-010 SHALL have port tx_data  in  DATA_BITS  character to send.
- REQ-011 SHALL have port tx_valid / tx_ready  in / out  1  valid-ready transmit handshake.
- REQ-012 SHALL have port rx_data  out  DATA_BITS  FIFO head character.
- REQ-013 SHALL have port rx_valid / rx_ready  out / in  1  valid-ready receive handshake.
- REQ-014 SHALL have port rx_err  out  3  FIFO-head flags {overrun, parity, framing}.
- REQ-015 SHALL have ports uart_rx  in  1  and uart_tx  out  1  serial lines, idle high.

Function
- REQ-016 TX FSM SHALL step IDLE -> START -> DATA -> PARITY (only if cfg_parity_en) -> STOP -> IDLE, each bit lasting exactly cfg_div clocks.
- REQ-017 tx_ready SHALL be high only in IDLE; a tx_valid&tx_ready cycle latches tx_data and drives uart_tx low on the next edge.
- REQ-018 DATA SHALL shift LSB first, DATA_BITS bits; parity is XOR of data bits, inverted when cfg_parity_odd.
- REQ-019 STOP SHALL last 1 or 2 bit times per cfg_stop2; tx_ready rises the cycle after the last stop bit ends.
- REQ-020 uart_rx SHALL pass through a 2-flop synchroniser (reset value 1) before use.
- REQ-021 RX FSM SHALL detect a falling edge in IDLE, resample at cfg_div/2 and return to IDLE without storing if the line is high (glitch).
- REQ-022 RX SHALL sample data, parity and first stop bit at mid-bit (every cfg_div clocks after the start-bit centre).
- REQ-023 Parity mismatch SHALL set parity flag; stop bit sampled low SHALL set framing flag; the character is stored regardless.
- REQ-024 RX SHALL check only the first stop bit and re-arm in IDLE directly after sampling it.
- REQ-025 RX FIFO SHALL store {flags, data}; rx_valid = not empty; pop on rx_valid&rx_ready.
- REQ-026 On write while full, the new character SHALL be dropped and the overrun flag set on the newest stored entry.
- REQ-027 Simultaneous push and pop when full SHALL succeed without overrun.
- REQ-028 Config inputs SHALL be sampled at frame start; changes mid-frame affect only the next frame.

Reset
- REQ-029 Asserting rst_n low SHALL, at any time including mid-frame, force both FSMs to IDLE, empty the FIFO, and drive uart_tx=1, tx_ready=0, rx_valid=0, rx_data=0, rx_err=0.
- REQ-030 tx_ready SHALL rise on the first clock edge after reset release.

Configuration
- REQ-031 With UART_BFM_TRX_LOOPBACK_EN defined, SHALL add input cfg_loopback; when high the RX path takes the internal TX line and uart_tx holds 1.
- REQ-032 Without UART_BFM_TRX_LOOPBACK_EN, cfg_loopback SHALL not exist and RX always uses uart_rx.

Structure
- REQ-033 Package uart_bfm_pkg SHALL hold the TX/RX state enums, the rx_err bit-index constants and the minimum-divisor constant (4).
- REQ-034 The FIFO SHALL be one sub-module uart_bfm_fifo (parametrised width/depth, full/empty, count); serialiser and deserialiser stay in uart_bfm_trx.

Verification
- REQ-035 cfg_div=8, 8N1, send 0x65 -> uart_tx low 8 clks, then 1,0,1,0,0,1,1,0 at 8 clks each, high 8 clks; tx_ready back after 80 clks.
- REQ-036 TX->RX loopback (macro on), 8E2, send 0xA5 -> rx_data=0xA5, rx_err=0; even parity bit 0 observed.
- REQ-037 Inject 0x3C with wrong parity then 0x3C with stop=0 -> rx_err=010 then 001; both characters stored.
- REQ-038 FIFO_DEPTH=4, rx_ready=0, receive 5 characters -> 4 stored, 4th entry rx_err overrun=1, 5th dropped.
- REQ-039 2-clk low glitch on uart_rx at cfg_div=16 -> nothing stored, RX back in IDLE.
- REQ-040 rst_n low mid-data bit during TX and RX -> uart_tx=1, rx_valid=0 next sample; clean 0x55 frame afterwards sends/receives correctly.

Source files
------------

// File: rtl/uart_bfm_pkg.sv
// Shared state enums and constants for the uart_bfm_trx UART model.
package uart_bfm_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Bit positions inside rx_err; overrun must stay the MSB of a stored word.
  localparam int ERR_OVERRUN = 2;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_FRAMING = 0;

  localparam int MIN_DIV = 4;

endpackage

// File: rtl/uart_bfm_fifo.sv
// Receive FIFO: a push that finds it full (with no pop) is dropped and sets the
// MSB of the newest stored word, which the UART uses as its overrun flag.
module uart_bfm_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop, do_mark;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign do_mark = push && full && !do_pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count are, and an empty FIFO is masked downstream.
  always_ff @(posedge clk) begin
    if (do_push)      mem[wr_ptr_q] <= wr_data;
    else if (do_mark) mem[wr_ptr_q - PTR_ONE][WIDTH-1] <= 1'b1;
  end

endmodule

// File: rtl/uart_bfm_trx.sv
// UART transmitter/receiver BFM with RX FIFO. Define UART_BFM_TRX_LOOPBACK_EN
// to add cfg_loopback, which routes the internal TX line into RX.
module uart_bfm_trx
  import uart_bfm_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
`ifdef UART_BFM_TRX_LOOPBACK_EN
  input  logic                 cfg_loopback,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [2:0]           rx_err,
  input  logic                 uart_rx,
  output logic                 uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = FIFO_DEPTH[CW-1:0];
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
  logic                 tx_stop_left_q, tx_stop_left_d;
  logic                 tx_line_q, tx_line_d, tx_ready_q, tx_ready_d;

  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    tx_div_d       = tx_div_q;
    tx_shift_d     = tx_shift_q;
    tx_bit_d       = tx_bit_q;
    tx_par_en_d    = tx_par_en_q;
    tx_par_bit_d   = tx_par_bit_q;
    tx_stop_left_d = tx_stop_left_q;
    tx_line_d      = tx_line_q;
    if (tx_state_q == TX_IDLE) begin
      tx_line_d = 1'b1;
      if (tx_valid && tx_ready_q) begin
        tx_state_d     = TX_START;
        tx_line_d      = 1'b0;
        tx_div_d       = div_eff;
        tx_cnt_d       = div_eff - DIV_W'(1);
        tx_shift_d     = tx_data;
        tx_bit_d       = '0;
        tx_par_en_d    = cfg_parity_en;
        tx_par_bit_d   = (^tx_data) ^ cfg_parity_odd;
        tx_stop_left_d = cfg_stop2;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - DIV_W'(1);
    end else begin
      tx_cnt_d = tx_div_q - DIV_W'(1);
      case (tx_state_q)
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_line_d  = tx_shift_q[0];
        end
        TX_DATA: begin
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
            tx_line_d  = tx_par_en_q ? tx_par_bit_q : 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end
        TX_PARITY: begin
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end
        TX_STOP: begin
          if (tx_stop_left_q) tx_stop_left_d = 1'b0;
          else                tx_state_d     = TX_IDLE;
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q     <= TX_IDLE;
      tx_cnt_q       <= '0;
      tx_div_q       <= '0;
      tx_shift_q     <= '0;
      tx_bit_q       <= '0;
      tx_par_en_q    <= 1'b0;
      tx_par_bit_q   <= 1'b0;
      tx_stop_left_q <= 1'b0;
      tx_line_q      <= 1'b1;
      tx_ready_q     <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_div_q       <= tx_div_d;
      tx_shift_q     <= tx_shift_d;
      tx_bit_q       <= tx_bit_d;
      tx_par_en_q    <= tx_par_en_d;
      tx_par_bit_q   <= tx_par_bit_d;
      tx_stop_left_q <= tx_stop_left_d;
      tx_line_q      <= tx_line_d;
      tx_ready_q     <= tx_ready_d;
    end
  end

  assign tx_ready = tx_ready_q;

  logic rx_line;
`ifdef UART_BFM_TRX_LOOPBACK_EN
  assign rx_line = cfg_loopback ? tx_line_q : uart_rx;
  assign uart_tx = cfg_loopback ? 1'b1 : tx_line_q;
`else
  assign rx_line = uart_rx;
  assign uart_tx = tx_line_q;
`endif

  // ---------------- receiver ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rx_in, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic                 rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic                 rx_par_err_q, rx_par_err_d;
  logic                 rx_push;
  logic [2:0]           rx_flags;

  assign rx_in = rx_sync_q[1];

  always_comb begin
    rx_sync_d    = {rx_sync_q[0], rx_line};
    rx_prev_d    = rx_in;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_div_d     = rx_div_q;
    rx_shift_d   = rx_shift_q;
    rx_bit_d     = rx_bit_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_par_err_d = rx_par_err_q;
    rx_push      = 1'b0;
    rx_flags              = '0;
    rx_flags[ERR_PARITY]  = rx_par_err_q;
    rx_flags[ERR_FRAMING] = ~rx_in;
    if (rx_state_q == RX_IDLE) begin
      if (rx_prev_q && !rx_in) begin
        rx_state_d   = RX_START;
        rx_div_d     = div_eff;
        rx_cnt_d     = (div_eff >> 1) - DIV_W'(1);
        rx_bit_d     = '0;
        rx_par_en_d  = cfg_parity_en;
        rx_par_odd_d = cfg_parity_odd;
        rx_par_err_d = 1'b0;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - DIV_W'(1);
    end else begin
      rx_cnt_d = rx_div_q - DIV_W'(1);
      case (rx_state_q)
        RX_START: rx_state_d = rx_in ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 4'd1;
        end
        RX_PARITY: begin
          rx_par_err_d = rx_in ^ (^rx_shift_q) ^ rx_par_odd_q;
          rx_state_d   = RX_STOP;
        end
        RX_STOP: begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= '0;
      rx_shift_q   <= '0;
      rx_bit_q     <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_par_err_q <= 1'b0;
    end else begin
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_shift_q   <= rx_shift_d;
      rx_bit_q     <= rx_bit_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
      rx_par_err_q <= rx_par_err_d;
    end
  end

  // ---------------- receive FIFO ----------------
  logic [DATA_BITS+2:0] fifo_head;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]        fifo_count;

  assign fifo_pop = rx_ready && !fifo_empty;

  uart_bfm_fifo #(
    .WIDTH (DATA_BITS + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rx_push),
    .wr_data ({rx_flags, rx_shift_q}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_empty ? '0 : fifo_head[DATA_BITS-1:0];
  assign rx_err   = fifo_empty ? '0 : fifo_head[DATA_BITS+2:DATA_BITS];

  assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> (fifo_count == CNT_FULL));

endmodule

// File: tb/tb_uart_bfm_trx.sv
// Directed self-checking bench for uart_bfm_trx (FIFO_DEPTH=4, 8-bit characters).
module tb_uart_bfm_trx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_div = 16'd8;
  logic        cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0, cfg_stop2 = 1'b0;
  logic        cfg_loopback = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0, rx_ready = 1'b0;
  logic        tx_ready, rx_valid, uart_tx;
  logic [7:0]  rx_data;
  logic [2:0]  rx_err;
  logic        rx_drv = 1'b1, loop_sel = 1'b0;
  wire         uart_rx = loop_sel ? uart_tx : rx_drv;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_bfm_trx #(.DIV_W(16), .FIFO_DEPTH(4), .DATA_BITS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_div        (cfg_div),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
`ifdef UART_BFM_TRX_LOOPBACK_EN
    .cfg_loopback   (cfg_loopback),
`endif
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_err         (rx_err),
    .uart_rx        (uart_rx),
    .uart_tx        (uart_tx)
  );

  // Handshake one character; returns at the first negedge after the accepting edge.
  task automatic start_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      total++; bad++;
      $display("FAIL tx_ready_wait: got %b want 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (int'(cfg_div)) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic has_par, input logic par,
                             input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  // Waits (bounded) for a character and pops it; got=0 if none arrived.
  task automatic pop_rx(output logic got, output logic [7:0] d, output logic [2:0] e);
    int n = 0;
    got = 1'b0; d = '0; e = '0;
    while (!rx_valid && n < 400) begin @(negedge clk); n++; end
    if (rx_valid) begin
      got = 1'b1; d = rx_data; e = rx_err;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (rx_err !== 3'b000) begin bad++; $display("FAIL reset_rx_err: got %b want 000", rx_err); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_tx_8n1;
    logic [9:0] frame;
    cfg_div = 16'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; loop_sel = 1'b0;
    frame = {1'b1, 8'h65, 1'b0};
    start_tx(8'h65);
    for (int k = 0; k < 80; k++) begin
      total++;
      if (uart_tx !== frame[k/8]) begin
        bad++; $display("FAIL tx_8n1_bit k=%0d: got %b want %b", k, uart_tx, frame[k/8]);
      end
      total++;
      if (tx_ready !== 1'b0) begin bad++; $display("FAIL tx_8n1_busy k=%0d: got %b want 0", k, tx_ready); end
      @(negedge clk);
    end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL tx_8n1_ready_back: got %b want 1", tx_ready); end
  endtask

  task automatic test_loopback_8e2;
    logic got; logic [7:0] d; logic [2:0] e;
    cfg_div = 16'd8; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
    loop_sel = 1'b1;
    start_tx(8'hA5);
    for (int k = 0; k < 96; k++) begin
      if (k == 76) begin
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL lb_parity_bit: got %b want 0", uart_tx); end
      end
      if (k == 84 || k == 92) begin
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL lb_stop k=%0d: got %b want 1", k, uart_tx); end
      end
      @(negedge clk);
    end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL lb_ready_after_2stop: got %b want 1", tx_ready); end
    pop_rx(got, d, e);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL lb_rx_arrive: got %b want 1", got); end
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL lb_rx_data: got %h want a5", d); end
    total++; if (e !== 3'b000) begin bad++; $display("FAIL lb_rx_err: got %b want 000", e); end
    loop_sel = 1'b0;
  endtask

  task automatic test_parity_framing;
    logic got; logic [7:0] d; logic [2:0] e;
    cfg_div = 16'd8; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    drive_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    drive_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1);
    pop_rx(got, d, e);
    total++; if (got !== 1'b1 || d !== 8'h3C) begin bad++; $display("FAIL par_char: got %b/%h want 1/3c", got, d); end
    total++; if (e !== 3'b010) begin bad++; $display("FAIL par_flag: got %b want 010", e); end
    pop_rx(got, d, e);
    total++; if (got !== 1'b1 || d !== 8'h3C) begin bad++; $display("FAIL frm_char: got %b/%h want 1/3c", got, d); end
    total++; if (e !== 3'b001) begin bad++; $display("FAIL frm_flag: got %b want 001", e); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL par_frm_empty: got %b want 0", rx_valid); end
  endtask

  task automatic test_overrun;
    logic got; logic [7:0] d; logic [2:0] e;
    logic [7:0] chars [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cfg_div = 16'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_frame(chars[i], 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) begin
      pop_rx(got, d, e);
      total++;
      if (got !== 1'b1 || d !== chars[i]) begin
        bad++; $display("FAIL ovr_char%0d: got %b/%h want 1/%h", i, got, d, chars[i]);
      end
      total++;
      if (e !== ((i == 3) ? 3'b100 : 3'b000)) begin
        bad++; $display("FAIL ovr_flag%0d: got %b want %b", i, e, (i == 3) ? 3'b100 : 3'b000);
      end
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_fifth_dropped: got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch;
    logic got; logic [7:0] d; logic [2:0] e;
    cfg_div = 16'd16; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_stored: got %b want 0", rx_valid); end
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    pop_rx(got, d, e);
    total++; if (got !== 1'b1 || d !== 8'h5A) begin bad++; $display("FAIL glitch_rearm: got %b/%h want 1/5a", got, d); end
    total++; if (e !== 3'b000) begin bad++; $display("FAIL glitch_rearm_err: got %b want 000", e); end
  endtask

  task automatic test_reset_midframe;
    logic got; logic [7:0] d; logic [2:0] e;
    logic [9:0] frame;
    cfg_div = 16'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; loop_sel = 1'b1;
    start_tx(8'h00);
    repeat (28) @(negedge clk);
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_data_low: got %b want 0", uart_tx); end
    rst_n = 1'b0;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_rst_uart_tx: got %b want 1", uart_tx); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rx_valid: got %b want 0", rx_valid); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_tx_ready: got %b want 0", tx_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame = {1'b1, 8'h55, 1'b0};
    start_tx(8'h55);
    for (int k = 0; k < 80; k++) begin
      if (k % 8 == 4) begin
        total++;
        if (uart_tx !== frame[k/8]) begin
          bad++; $display("FAIL post_rst_tx bit%0d: got %b want %b", k/8, uart_tx, frame[k/8]);
        end
      end
      @(negedge clk);
    end
    pop_rx(got, d, e);
    total++; if (got !== 1'b1 || d !== 8'h55) begin bad++; $display("FAIL post_rst_rx: got %b/%h want 1/55", got, d); end
    total++; if (e !== 3'b000) begin bad++; $display("FAIL post_rst_rx_err: got %b want 000", e); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL post_rst_single: got %b want 0", rx_valid); end
    loop_sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_tx_8n1;
    test_loopback_8e2;
    test_parity_framing;
    test_overrun;
    test_glitch;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
